// File: rtl/circ_fifo_pkg.sv
// ============================================================================
// circ_fifo_pkg : shared helpers for the circular FIFO slice.  Rev 1.0
// ============================================================================
`default_nettype none

package circ_fifo_pkg;

  // Legal FIFO depth: a power of two, at least 2.
  function automatic bit is_valid_depth(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// fifo_ptr : wrap-bit pointer counter with increment and clear.  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  output logic [PTR_W:0] ptr
);

  localparam logic [PTR_W:0] C_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] r_ptr;

  // Clear wins over increment so a flush discards any same-cycle fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + C_ONE;
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/register.sv
// ============================================================================
// register : write-enabled storage register, async active-low reset.  Rev 1.0
// ============================================================================
`default_nettype none

module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/circ_fifo.sv
// ============================================================================
// circ_fifo : circular valid/ready FIFO with flush and occupancy count.  Rev 1.0
// ============================================================================
`default_nettype none

module circ_fifo
  import circ_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [WIDTH-1:0]         enq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [WIDTH-1:0]         deq_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  generate
    if (!is_valid_depth(DEPTH)) begin : g_depth_check
      $error("circ_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [PTR_W:0]   w_wr_ptr;
  logic [PTR_W:0]   w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [WIDTH-1:0] w_entry [DEPTH];

  assign w_empty    = (w_wr_ptr == w_rd_ptr);
  assign w_full     = (w_wr_ptr[PTR_W-1:0] == w_rd_ptr[PTR_W-1:0]) &&
                      (w_wr_ptr[PTR_W] != w_rd_ptr[PTR_W]);
  // enq_ready is purely a function of stored state, never of deq_ready.
  assign enq_ready  = !w_full;
  assign deq_valid  = !w_empty;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;
  assign count      = w_wr_ptr - w_rd_ptr;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (w_enq_fire),
    .ptr (w_wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (w_deq_fire),
    .ptr (w_rd_ptr)
  );

  // Entry contents are don't-care after reset, so storage reset is tied off.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      register #(.WIDTH(WIDTH)) u_entry (
        .clk (clk),
        .rst (1'b1),
        .en  (w_enq_fire && (w_wr_ptr[PTR_W-1:0] == PTR_W'(i))),
        .d   (enq_data),
        .q   (w_entry[i])
      );
    end
  endgenerate

  assign deq_data = w_entry[w_rd_ptr[PTR_W-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_circ_fifo.sv
// ============================================================================
// tb_circ_fifo : randomized and directed checks of circ_fifo against a queue.
// ============================================================================
`default_nettype none

module tb_circ_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic [3:0]       count;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] model_q [$];
  bit last_enq_fire;

  circ_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(count), 64'(model_q.size()));
    chk("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'(model_q.size() > 0));
    if (model_q.size() > 0) chk("deq_data", 64'(deq_data), 64'(model_q[0]));
  endtask

  // Drive one cycle from posedge+1, check on negedge, advance model at posedge.
  task automatic step(input bit ev, input logic [WIDTH-1:0] ed, input bit dr, input bit fl);
    int sz;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    sz = model_q.size();
    last_enq_fire = 1'b0;
    if (!rst || fl) begin
      model_q.delete();
    end else begin
      if (dr && sz > 0) void'(model_q.pop_front());
      if (ev && sz < DEPTH) begin
        model_q.push_back(ed);
        last_enq_fire = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    bit              pend_v;
    logic [WIDTH-1:0] pend_d;
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;

    // Reset held for two cycles, then idle.
    @(posedge clk); #1;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);

    // Fill, attempt overflow, drain.
    for (int k = 1; k <= 8; k++) step(1, WIDTH'(32'h11 * k), 0, 0);
    step(1, 32'h99, 0, 0);
    chk("overflow_rejected", 64'(last_enq_fire), 64'(0));
    for (int k = 0; k < 8; k++) step(0, '0, 1, 0);

    // Wrap and concurrent enq/deq.
    for (int k = 0; k < 5; k++) step(1, WIDTH'(32'h100 + k), 0, 0);
    for (int k = 0; k < 5; k++) step(0, '0, 1, 0);
    for (int k = 0; k < 20; k++) step(1, WIDTH'(32'h200 + k), 1, 0);
    step(0, '0, 1, 0);

    // Full with simultaneous deq: no enq admitted that cycle.
    for (int k = 0; k < 8; k++) step(1, WIDTH'(32'h300 + k), 0, 0);
    step(1, 32'h3AA, 1, 0);
    chk("full_deq_no_enq", 64'(last_enq_fire), 64'(0));
    step(1, 32'h3AA, 0, 0);
    chk("enq_after_pop", 64'(last_enq_fire), 64'(1));
    for (int k = 0; k < 8; k++) step(0, '0, 1, 0);

    // Flush overrides same-cycle enq and deq.
    for (int k = 0; k < 3; k++) step(1, WIDTH'(32'h400 + k), 0, 0);
    step(1, 32'hDEAD, 1, 1);
    step(0, '0, 0, 0);
    step(1, 32'h500, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Async reset between edges.
    for (int k = 0; k < 6; k++) step(1, WIDTH'(32'h600 + k), 0, 0);
    chk("pre_reset_count", 64'(count), 64'(6));
    #2 rst = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'(0));
    chk("async_deq_valid", 64'(deq_valid), 64'(0));
    chk("async_enq_ready", 64'(enq_ready), 64'(1));
    model_q.delete();
    @(posedge clk); #1;
    step(0, '0, 0, 0);
    rst = 1'b1;

    // Randomized traffic; producer holds its offer until accepted.
    pend_v = 1'b0;
    pend_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 99) < 60);
        pend_d = $urandom;
      end
      step(pend_v, pend_d, ($urandom_range(0, 99) < 45), ($urandom_range(0, 63) == 0));
      if (last_enq_fire || flush) pend_v = 1'b0;
    end
    step(0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
